riffa_cmd_endpoint: RTL and testbench

//  User-side terminator of the RIFFA CMD channel (channel 0); drives the CHNL_CMD_* signals of chnl_connector.

---
 rtl/riffa_cmd_endpoint_if.sv | 51 +++++
 rtl/riffa_cmd_endpoint.sv | 159 +++++++++++++++
 tb/tb_riffa_cmd_endpoint.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riffa_cmd_endpoint_if.sv
// RIFFA CMD channel (chnl_connector side) plus the register bus driven by riffa_cmd_endpoint.
// slave = the endpoint; master = the host channel together with the register file.
interface riffa_cmd_endpoint_if #(
  parameter int ADDR_W = 8
);
  logic              CHNL_CMD_RX_CLK;
  logic              CHNL_CMD_RX;
  logic              CHNL_CMD_RX_ACK;
  logic              CHNL_CMD_RX_LAST;
  logic [31:0]       CHNL_CMD_RX_LEN;
  logic [30:0]       CHNL_CMD_RX_OFF;
  logic [31:0]       CHNL_CMD_RX_DATA;
  logic              CHNL_CMD_RX_DATA_VALID;
  logic              CHNL_CMD_RX_DATA_REN;
  logic              CHNL_CMD_TX_CLK;
  logic              CHNL_CMD_TX;
  logic              CHNL_CMD_TX_ACK;
  logic              CHNL_CMD_TX_LAST;
  logic [31:0]       CHNL_CMD_TX_LEN;
  logic [30:0]       CHNL_CMD_TX_OFF;
  logic [31:0]       CHNL_CMD_TX_DATA;
  logic              CHNL_CMD_TX_DATA_VALID;
  logic              CHNL_CMD_TX_DATA_REN;
  logic              REG_WR_EN;
  logic              REG_RD_EN;
  logic [ADDR_W-1:0] REG_ADDR;
  logic [31:0]       REG_WR_DATA;
  logic [31:0]       REG_RD_DATA;

  modport slave (
    output CHNL_CMD_RX_CLK, CHNL_CMD_RX_ACK, CHNL_CMD_RX_DATA_REN,
    input  CHNL_CMD_RX, CHNL_CMD_RX_LAST, CHNL_CMD_RX_LEN, CHNL_CMD_RX_OFF,
    input  CHNL_CMD_RX_DATA, CHNL_CMD_RX_DATA_VALID,
    output CHNL_CMD_TX_CLK, CHNL_CMD_TX, CHNL_CMD_TX_LAST, CHNL_CMD_TX_LEN,
    output CHNL_CMD_TX_OFF, CHNL_CMD_TX_DATA, CHNL_CMD_TX_DATA_VALID,
    input  CHNL_CMD_TX_ACK, CHNL_CMD_TX_DATA_REN,
    output REG_WR_EN, REG_RD_EN, REG_ADDR, REG_WR_DATA,
    input  REG_RD_DATA
  );

  modport master (
    input  CHNL_CMD_RX_CLK, CHNL_CMD_RX_ACK, CHNL_CMD_RX_DATA_REN,
    output CHNL_CMD_RX, CHNL_CMD_RX_LAST, CHNL_CMD_RX_LEN, CHNL_CMD_RX_OFF,
    output CHNL_CMD_RX_DATA, CHNL_CMD_RX_DATA_VALID,
    input  CHNL_CMD_TX_CLK, CHNL_CMD_TX, CHNL_CMD_TX_LAST, CHNL_CMD_TX_LEN,
    input  CHNL_CMD_TX_OFF, CHNL_CMD_TX_DATA, CHNL_CMD_TX_DATA_VALID,
    output CHNL_CMD_TX_ACK, CHNL_CMD_TX_DATA_REN,
    input  REG_WR_EN, REG_RD_EN, REG_ADDR, REG_WR_DATA,
    output REG_RD_DATA
  );
endinterface

// File: rtl/riffa_cmd_endpoint.sv
// RIFFA CMD channel terminator: 2-word register commands in, one 1-word reply out, one command in flight.
// RX is stalled (no ACK) until the previous reply is fully sent; TX request/data held until host ACK and REN.
module riffa_cmd_endpoint #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int ADDR_W           = 8
) (
  input logic                 CLK,
  input logic                 RST_N,
  riffa_cmd_endpoint_if.slave bus
);

  if (C_PCI_DATA_WIDTH != 32) begin : g_bad_width
    $error("riffa_cmd_endpoint: only C_PCI_DATA_WIDTH = 32 is supported");
  end
  if (ADDR_W < 1 || ADDR_W > 28) begin : g_bad_addr_w
    $error("riffa_cmd_endpoint: ADDR_W must be within 1..28");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_RECV, S_EXEC, S_RDWAIT, S_REPLY
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_len;
  logic [31:0]       r_cnt;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_reply;
  logic              r_bad_len;
  logic              r_tx_acked;
  logic              r_tx_sent;

  logic w_is_wr, w_is_rd, w_bad_op;
  logic w_rx_xfer, w_rx_last, w_tx_xfer, w_tx_done;
  logic w_rx_ack, w_ren, w_tx, w_tx_vld, w_wr_en, w_rd_en;
  logic w_unused;

  function automatic logic [31:0] f_status(input logic bad_op, input logic bad_len);
    return {30'h0, bad_op, bad_len};
  endfunction

  assign w_is_wr   = (r_op == 2'b01);
  assign w_is_rd   = (r_op == 2'b10);
  assign w_bad_op  = !w_is_wr && !w_is_rd;
  assign w_rx_xfer = (r_state == S_RECV) && bus.CHNL_CMD_RX_DATA_VALID;
  assign w_rx_last = w_rx_xfer && (r_cnt == r_len - 32'd1);
  assign w_tx_xfer = (r_state == S_REPLY) && !r_tx_sent && bus.CHNL_CMD_TX_DATA_REN;
  // ACK and the word transfer may arrive in either order or together
  assign w_tx_done = (r_tx_acked || bus.CHNL_CMD_TX_ACK) && (r_tx_sent || w_tx_xfer);

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rx_ack    = 1'b0;
    w_ren       = 1'b0;
    w_tx        = 1'b0;
    w_tx_vld    = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.CHNL_CMD_RX) w_state_nxt = S_ACK;
      S_ACK: begin
        w_rx_ack    = 1'b1;
        w_state_nxt = (r_len == 32'd0) ? S_REPLY : S_RECV;
      end
      S_RECV: begin
        w_ren = 1'b1;
        if (w_rx_last) w_state_nxt = (r_len == 32'd2) ? S_EXEC : S_REPLY;
      end
      S_EXEC: begin
        w_wr_en     = w_is_wr;
        w_rd_en     = w_is_rd;
        w_state_nxt = w_is_rd ? S_RDWAIT : S_REPLY;
      end
      S_RDWAIT: w_state_nxt = S_REPLY;
      S_REPLY: begin
        w_tx     = 1'b1;
        w_tx_vld = !r_tx_sent;
        if (w_tx_done) w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_op       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_reply    <= '0;
      r_bad_len  <= 1'b0;
      r_tx_acked <= 1'b0;
      r_tx_sent  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.CHNL_CMD_RX) begin
          r_len      <= bus.CHNL_CMD_RX_LEN;
          r_cnt      <= '0;
          r_bad_len  <= 1'b0;
          r_tx_acked <= 1'b0;
          r_tx_sent  <= 1'b0;
        end
        S_ACK: if (r_len == 32'd0) begin
          r_bad_len <= 1'b1;
          r_reply   <= f_status(1'b0, 1'b1);
        end
        S_RECV: if (w_rx_xfer) begin
          r_cnt <= r_cnt + 32'd1;
          if (r_cnt == 32'd0) begin
            r_op   <= bus.CHNL_CMD_RX_DATA[31:30];
            r_addr <= bus.CHNL_CMD_RX_DATA[ADDR_W-1:0];
          end
          if (r_cnt == 32'd1) r_wdata <= bus.CHNL_CMD_RX_DATA;
          if (w_rx_last && r_len != 32'd2) begin
            r_bad_len <= 1'b1;
            r_reply   <= f_status(1'b0, 1'b1);
          end
        end
        S_EXEC: begin
          if (w_bad_op)     r_reply <= f_status(1'b1, r_bad_len);
          else if (w_is_wr) r_reply <= '0;
        end
        // read data is valid exactly one cycle after the strobe
        S_RDWAIT: r_reply <= bus.REG_RD_DATA;
        S_REPLY: begin
          if (bus.CHNL_CMD_TX_ACK) r_tx_acked <= 1'b1;
          if (w_tx_xfer)           r_tx_sent  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.CHNL_CMD_RX_CLK        = CLK;
  assign bus.CHNL_CMD_TX_CLK        = CLK;
  assign bus.CHNL_CMD_RX_ACK        = w_rx_ack;
  assign bus.CHNL_CMD_RX_DATA_REN   = w_ren;
  assign bus.CHNL_CMD_TX            = w_tx;
  assign bus.CHNL_CMD_TX_LAST       = w_tx;
  assign bus.CHNL_CMD_TX_LEN        = {31'h0, w_tx};
  assign bus.CHNL_CMD_TX_OFF        = '0;
  assign bus.CHNL_CMD_TX_DATA       = r_reply;
  assign bus.CHNL_CMD_TX_DATA_VALID = w_tx_vld;
  assign bus.REG_WR_EN              = w_wr_en;
  assign bus.REG_RD_EN              = w_rd_en;
  assign bus.REG_ADDR               = r_addr;
  assign bus.REG_WR_DATA            = r_wdata;

  assign w_unused = ^{bus.CHNL_CMD_RX_LAST, bus.CHNL_CMD_RX_OFF};

endmodule

// File: tb/tb_riffa_cmd_endpoint.sv
// Bench for riffa_cmd_endpoint: host RX/TX driver, register-file responder and reply/strobe scoreboard.
module tb_riffa_cmd_endpoint;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riffa_cmd_endpoint_if #(.ADDR_W(AW)) bus ();
  riffa_cmd_endpoint #(.C_PCI_DATA_WIDTH(32), .ADDR_W(AW)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int errors = 0;
  int checks = 0;
  int n_ack = 0, n_ren = 0, n_words = 0, n_wr = 0, n_rd = 0, n_rpl = 0;
  wr_t           wrq[$];
  logic [AW-1:0] rdq[$];
  logic [31:0]   rplq[$];
  logic [31:0]   rd_val;
  bit            rd_en_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {21'h0, bus.CHNL_CMD_RX_ACK, bus.CHNL_CMD_RX_DATA_REN, bus.CHNL_CMD_TX,
            bus.CHNL_CMD_TX_DATA_VALID, bus.REG_WR_EN, bus.REG_RD_EN, bus.CHNL_CMD_TX_LAST,
            |bus.CHNL_CMD_TX_LEN, |bus.CHNL_CMD_TX_DATA, |bus.REG_ADDR, |bus.REG_WR_DATA};
  endfunction

  // Monitor: counts events and pops the scoreboard as the DUT produces them.
  always @(negedge clk) begin
    rd_en_seen = bus.REG_RD_EN;
    if (bus.CHNL_CMD_RX_ACK) n_ack++;
    if (bus.CHNL_CMD_RX_DATA_REN) n_ren++;
    if (bus.CHNL_CMD_RX_DATA_REN && bus.CHNL_CMD_RX_DATA_VALID) n_words++;
    if (bus.REG_WR_EN) begin
      n_wr++;
      if (wrq.size() == 0) check("wr_unexpected", wrq.size(), 1);
      else begin
        wr_t e;
        e = wrq.pop_front();
        check("wr_addr", bus.REG_ADDR, e.addr);
        check("wr_data", bus.REG_WR_DATA, e.data);
      end
    end
    if (bus.REG_RD_EN) begin
      n_rd++;
      if (rdq.size() == 0) check("rd_unexpected", rdq.size(), 1);
      else check("rd_addr", bus.REG_ADDR, rdq.pop_front());
    end
    if (bus.CHNL_CMD_TX_DATA_VALID && bus.CHNL_CMD_TX_DATA_REN) begin
      n_rpl++;
      check("tx_len", bus.CHNL_CMD_TX_LEN, 1);
      check("tx_last", bus.CHNL_CMD_TX_LAST, 1);
      if (rplq.size() == 0) check("reply_unexpected", rplq.size(), 1);
      else check("reply", bus.CHNL_CMD_TX_DATA, rplq.pop_front());
    end
  end

  // Register file: read data appears one cycle after the strobe, garbage otherwise.
  always begin
    @(posedge clk);
    #1;
    bus.REG_RD_DATA = rd_en_seen ? rd_val : 32'hBAD0_0BAD;
  end

  task automatic host_rx(input logic [31:0] len, input logic [31:0] w0, input logic [31:0] w1,
                         input bit gaps, input bit keep_rx, input int abort_after, output bit ok);
    int t;
    ok = 1'b1;
    @(posedge clk); #1;
    bus.CHNL_CMD_RX     = 1'b1;
    bus.CHNL_CMD_RX_LEN = len;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.CHNL_CMD_RX_ACK && t < 50);
    if (!bus.CHNL_CMD_RX_ACK) begin
      check("rx_ack_seen", bus.CHNL_CMD_RX_ACK, 1);
      bus.CHNL_CMD_RX = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!keep_rx) bus.CHNL_CMD_RX = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      if (i == abort_after) return;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          bus.CHNL_CMD_RX_DATA_VALID = 1'b0;
          bus.CHNL_CMD_RX_DATA       = $urandom;
          @(posedge clk); #1;
        end
      end
      bus.CHNL_CMD_RX_DATA       = (i == 0) ? w0 : (i == 1) ? w1 : 32'h7000_0000 + i;
      bus.CHNL_CMD_RX_DATA_VALID = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.CHNL_CMD_RX_DATA_REN && t < 50);
      if (!bus.CHNL_CMD_RX_DATA_REN) begin
        check("rx_ren_seen", bus.CHNL_CMD_RX_DATA_REN, 1);
        bus.CHNL_CMD_RX_DATA_VALID = 1'b0;
        ok = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.CHNL_CMD_RX_DATA_VALID = 1'b0;
  endtask

  // TX_ACK pulses in cycle ack_cyc, REN asserted from ren_cyc; reply must hold until both happen.
  task automatic host_tx(input int ack_cyc, input int ren_cyc);
    int t, cyc;
    bit acked, sent, stable;
    logic [31:0] d0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.CHNL_CMD_TX && t < 50);
    check("tx_request", bus.CHNL_CMD_TX, 1);
    d0 = bus.CHNL_CMD_TX_DATA;
    acked = 1'b0; sent = 1'b0; stable = 1'b1; cyc = 0;
    while (!(acked && sent) && cyc < 100) begin
      @(posedge clk); #1;
      bus.CHNL_CMD_TX_ACK      = (cyc == ack_cyc);
      bus.CHNL_CMD_TX_DATA_REN = !sent && (cyc >= ren_cyc);
      @(negedge clk);
      if (bus.CHNL_CMD_TX_ACK) acked = 1'b1;
      if (!bus.CHNL_CMD_TX) stable = 1'b0;
      if (!sent) begin
        if (!bus.CHNL_CMD_TX_DATA_VALID || bus.CHNL_CMD_TX_DATA !== d0) stable = 1'b0;
        if (bus.CHNL_CMD_TX_DATA_REN && bus.CHNL_CMD_TX_DATA_VALID) sent = 1'b1;
      end else if (bus.CHNL_CMD_TX_DATA_VALID) stable = 1'b0;
      cyc++;
    end
    check("tx_done", {acked, sent}, 2'b11);
    check("tx_hold", stable, 1);
    @(posedge clk); #1;
    bus.CHNL_CMD_TX_ACK      = 1'b0;
    bus.CHNL_CMD_TX_DATA_REN = 1'b0;
    bus.CHNL_CMD_RX          = 1'b0;
    @(negedge clk);
    check("tx_release", {bus.CHNL_CMD_TX, bus.CHNL_CMD_TX_DATA_VALID}, 0);
  endtask

  task automatic run_cmd(input logic [31:0] len, input logic [31:0] w0, input logic [31:0] w1,
                         input bit gaps, input bit keep_rx, input int ack_cyc, input int ren_cyc);
    int a0, r0, d0, wr0, rd0, p0;
    logic [1:0] op;
    bit ok, exp_wr, exp_rd;
    wr_t e;
    op     = w0[31:30];
    exp_wr = (len == 2) && (op == 2'b01);
    exp_rd = (len == 2) && (op == 2'b10);
    if (len != 2) rplq.push_back(32'h1);
    else if (exp_wr) begin
      rplq.push_back(32'h0);
      e.addr = w0[AW-1:0];
      e.data = w1;
      wrq.push_back(e);
    end else if (exp_rd) begin
      rplq.push_back(rd_val);
      rdq.push_back(w0[AW-1:0]);
    end else rplq.push_back(32'h2);
    a0 = n_ack; r0 = n_ren; d0 = n_words; wr0 = n_wr; rd0 = n_rd; p0 = n_rpl;
    host_rx(len, w0, w1, gaps, keep_rx, -1, ok);
    if (ok) host_tx(ack_cyc, ren_cyc);
    check("ack_pulses", n_ack - a0, 1);
    check("words_taken", n_words - d0, len);
    check("wr_strobes", n_wr - wr0, {31'h0, exp_wr});
    check("rd_strobes", n_rd - rd0, {31'h0, exp_rd});
    check("replies", n_rpl - p0, 1);
    if (len == 0) check("ren_len0", n_ren - r0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    int p0, w0c;
    rst_n = 1'b0;
    bus.CHNL_CMD_RX = 1'b0;            bus.CHNL_CMD_RX_LAST = 1'b1;
    bus.CHNL_CMD_RX_LEN = '0;          bus.CHNL_CMD_RX_OFF = '0;
    bus.CHNL_CMD_RX_DATA = '0;         bus.CHNL_CMD_RX_DATA_VALID = 1'b0;
    bus.CHNL_CMD_TX_ACK = 1'b0;        bus.CHNL_CMD_TX_DATA_REN = 1'b0;
    bus.REG_RD_DATA = '0;              rd_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_cmd(2, 32'h4000_0012, 32'hDEAD_BEEF, 0, 0, 0, 0);
    rd_val = 32'hCAFE_F00D;
    run_cmd(2, 32'h8000_0034, 32'h1234_5678, 0, 0, 0, 0);
    run_cmd(5, 32'h4000_0012, 32'h1111_2222, 0, 0, 0, 0);
    run_cmd(0, 32'h4000_0012, 32'h1111_2222, 0, 0, 0, 0);
    run_cmd(2, 32'hC000_0001, 32'h3333_4444, 0, 0, 0, 0);
    run_cmd(2, 32'h0000_0001, 32'h5555_6666, 0, 0, 0, 0);
    run_cmd(1, 32'h8000_0001, 32'h0, 0, 0, 0, 0);
    run_cmd(2, 32'h4FF0_00AB, 32'h0BAD_CAFE, 1, 1, 10, 13);
    rd_val = 32'h1357_9BDF;
    run_cmd(2, 32'h8000_00AB, 32'h0, 1, 0, 6, 1);

    p0 = n_rpl; w0c = n_wr;
    host_rx(2, 32'h4000_0056, 32'hFFFF_0000, 0, 0, 1, ok);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_outputs", outs_vec(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_no_reply", n_rpl - p0, 0);
    check("reset_no_write", n_wr - w0c, 0);
    run_cmd(2, 32'h4000_0077, 32'h600D_F00D, 0, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      logic [31:0] len, w0;
      int sel;
      sel = $urandom_range(0, 3);
      len = (sel == 0) ? 32'd1 : (sel == 3) ? 32'd3 : 32'd2;
      w0  = {2'($urandom_range(0, 3)), 22'h0, 8'($urandom)};
      rd_val = $urandom;
      run_cmd(len, w0, $urandom, 1, k[0], $urandom_range(0, 4), $urandom_range(0, 4));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", rplq.size() + wrq.size() + rdq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
